// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants, state and Booth-op types for booth_multiplier
// Contents:
//   BOOTH_WIDTH  default operand width
//   state_t      FSM states (IDLE, RUN)
//   booth_op_t   per-iteration action (NOP, ADD, SUB)
//   booth_decode maps {Q[0], Q-1} to the action
package booth_pkg;

    localparam int BOOTH_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // 01 ends a run of ones (add M); 10 starts a run of ones (subtract M).
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration
// Ports:
//   a_i   [WIDTH:0]    accumulator A (one guard bit)
//   q_i   [WIDTH-1:0]  multiplier / low product half Q
//   qm1_i              Q-1 history bit
//   m_i   [WIDTH:0]    sign-extended multiplicand M
//   a_o, q_o, qm1_o    next values after add/sub and arithmetic right shift
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    booth_op_t      op;
    logic [WIDTH:0] sum;

    always_comb begin
        op = booth_decode(q_i[0], qm1_i);
        case (op)
            OP_ADD:  sum = a_i + m_i;
            OP_SUB:  sum = a_i - m_i;
            default: sum = a_i;
        endcase
        // Shift {sum, Q, Q-1} right by one, replicating the sign of sum.
        a_o   = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential signed radix-2 Booth multiplier with start/done handshake
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only while idle
//   x, y  [WIDTH-1:0] signed multiplicand / multiplier, captured on the accepting edge
//   busy              high while iterating
//   done              one-cycle pulse when product has just been updated
//   product [2W-1:0]  signed x*y, held until the next completion
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     a_step;
    logic [WIDTH-1:0]   q_step;
    logic               qm1_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i   (a_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .a_o   (a_step),
        .q_o   (q_step),
        .qm1_o (qm1_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        if (state_q == IDLE) begin
            if (start) begin
                // M carries a guard bit so negating -2^(WIDTH-1) stays exact.
                m_d     = {x[WIDTH-1], x};
                q_d     = y;
                a_d     = '0;
                qm1_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = RUN;
            end
        end else begin
            a_d   = a_step;
            q_d   = q_step;
            qm1_d = qm1_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                // The guard bit of A only duplicates the sign once all bits are consumed.
                product_d = {a_step[WIDTH-1:0], q_step};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - directed self-checking bench for booth_multiplier
module tb_booth_multiplier;

    localparam int W   = 32;
    localparam int LAT = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int failures;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) on negedges until done; lat = rising edges since the accept edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Issues one request from a negedge and returns the result and latency.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                          output logic [2*W-1:0] res, output int lat);
        @(negedge clk);
        x = xa; y = ya; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        res = product;
    endtask

    task automatic test_reset();
        logic [2*W-1:0] res;
        int lat;
        int seen;
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b product=%h required 0 0 0", busy, done, product);
        end
        rst_n = 1'b1;
        run_op(32'd2, 32'd1, res, lat);
        checks++;
        if (res !== 64'd2) begin
            failures++;
            $display("FAIL pre_abort_product got %h required %h", res, 64'd2);
        end
        // Start another op, then abort it mid-run.
        @(negedge clk);
        x = 32'd5; y = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            failures++;
            $display("FAIL abort_reset busy=%b done=%b product=%h required 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0 || product !== '0) begin
            failures++;
            $display("FAIL abort_no_done activity=%0d product=%h required 0 0", seen, product);
        end
    endtask

    task automatic test_signs();
        logic [W-1:0]   xs [6];
        logic [W-1:0]   ys [6];
        logic [2*W-1:0] ex [6];
        logic [2*W-1:0] res;
        int lat;
        xs[0] = 32'd2;          ys[0] = 32'hFFFF_FFFF; ex[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        xs[1] = 32'd2;          ys[1] = 32'd1;         ex[1] = 64'd2;
        xs[2] = 32'hFFFF_FFFE;  ys[2] = 32'hFFFF_FFFF; ex[2] = 64'd2;
        xs[3] = 32'hFFFF_FFFE;  ys[3] = 32'd1;         ex[3] = 64'hFFFF_FFFF_FFFF_FFFE;
        xs[4] = 32'd2;          ys[4] = 32'd0;         ex[4] = 64'd0;
        xs[5] = 32'd3;          ys[5] = 32'hFFFF_FFF9; ex[5] = 64'hFFFF_FFFF_FFFF_FFEB;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], ys[i], res, lat);
            checks++;
            if (res !== ex[i] || lat !== LAT) begin
                failures++;
                $display("FAIL sign_case%0d product=%h lat=%0d required %h lat=%0d",
                         i, res, lat, ex[i], LAT);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse%0d done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_wide_extremes();
        logic [W-1:0]   xs [4];
        logic [W-1:0]   ys [4];
        logic [2*W-1:0] ex [4];
        logic [2*W-1:0] res;
        int lat;
        xs[0] = 32'hFFFF_FFFE; ys[0] = 32'h0000_FFFF; ex[0] = 64'hFFFF_FFFF_FFFE_0002;
        xs[1] = 32'hFFFF_0001; ys[1] = 32'h0000_FFFF; ex[1] = 64'hFFFF_FFFF_0001_FFFF;
        xs[2] = 32'h8000_0000; ys[2] = 32'h8000_0000; ex[2] = 64'h4000_0000_0000_0000;
        xs[3] = 32'h7FFF_FFFF; ys[3] = 32'h8000_0000; ex[3] = 64'hC000_0000_8000_0000;
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], ys[i], res, lat);
            checks++;
            if (res !== ex[i] || lat !== LAT) begin
                failures++;
                $display("FAIL wide_case%0d product=%h lat=%0d required %h lat=%0d",
                         i, res, lat, ex[i], LAT);
            end
        end
    endtask

    task automatic test_handshake();
        logic [2*W-1:0] res;
        int lat;
        // Accept 2 * -1, then disturb inputs and pulse start while running.
        @(negedge clk);
        x = 32'd2; y = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || product !== 64'hC000_0000_8000_0000) begin
            failures++;
            $display("FAIL busy_after_accept busy=%b product=%h required 1 %h",
                     busy, product, 64'hC000_0000_8000_0000);
        end
        repeat (4) @(negedge clk);
        x = 32'd9; y = 32'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 32'h1234_5678; y = 32'h8765_4321;
        lat = 5;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            x = ~x;
        end
        checks++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== LAT) begin
            failures++;
            $display("FAIL ignore_start product=%h lat=%0d required %h lat=%0d",
                     product, lat, 64'hFFFF_FFFF_FFFF_FFFE, LAT);
        end
        // Start during the done cycle must be accepted.
        x = 32'hFFFF_FFFE; y = 32'h0000_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_accept busy=%b done=%b required 1 0", busy, done);
        end
        wait_done(lat);
        res = product;
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFE_0002 || lat !== LAT) begin
            failures++;
            $display("FAIL back_to_back_result product=%h lat=%0d required %h lat=%0d",
                     res, lat, 64'hFFFF_FFFF_FFFE_0002, LAT);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 64'hFFFF_FFFF_FFFE_0002) begin
            failures++;
            $display("FAIL hold_after_done done=%b busy=%b product=%h required 0 0 %h",
                     done, busy, product, 64'hFFFF_FFFF_FFFE_0002);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_signs();
        test_wide_extremes();
        test_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
